// File: rtl/mem_stage_pkg.sv
// Shared size encodings, FSM state type and lane helpers for the MEM-stage access block.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Half accesses only look at a[1]; a misaligned a[0] is simply dropped.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_enable = 4'b0001 << lo;
      SZ_HALF: byte_enable = 4'b0011 << {lo[1], 1'b0};
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] rt);
    case (size)
      SZ_BYTE: lane_replicate = {4{rt[7:0]}};
      SZ_HALF: lane_replicate = {2{rt[15:0]}};
      default: lane_replicate = rt;
    endcase
  endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/half lane out of a little-endian read word and extends it to 32 bits.
module load_aligner
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size[1:0])
      SZ_BYTE: data = size[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: data = size[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access: req/ack handshake with stall, timeout abort, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped via o_misalign.
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int NBITS   = 32,
  parameter int RBITS   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NBITS-1:0] MEM_result,
  input  logic [NBITS-1:0] MEM_Rt,
  input  logic [RBITS-1:0] MEM_rd,
  input  logic             MEM_memtoreg,
  input  logic             MEM_memread,
  input  logic             MEM_memwrite,
  input  logic             MEM_regwrite,
  input  logic [4:0]       MEM_sizecontrol,
  output logic             o_dm_req,
  output logic             o_dm_we,
  output logic [NBITS-1:0] o_dm_addr,
  output logic [NBITS-1:0] o_dm_wdata,
  output logic [3:0]       o_dm_be,
  input  logic             i_dm_ack,
  input  logic [NBITS-1:0] i_dm_rdata,
  output logic             o_stall,
  output logic             o_bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic             o_misalign,
`endif
  output logic [NBITS-1:0] WB_readdata,
  output logic [NBITS-1:0] WB_result,
  output logic [RBITS-1:0] WB_rd,
  output logic             WB_memtoreg,
  output logic             WB_regwrite
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t            state, next_state;
  logic [CW-1:0]     cnt;
  logic              mem_op, misaligned, start, timeout;
  logic [NBITS-1:0]  addr_p1, wdata_p1, aligned;
  logic [3:0]        be_p1;
  logic              we_p1;
  logic [1:0]        lo_p1;
  logic [2:0]        size_p1;
  logic              unused_size;

  assign unused_size = ^MEM_sizecontrol[4:3];
  assign mem_op      = MEM_memread | MEM_memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op &&
                      ((MEM_sizecontrol[1:0] == SZ_HALF && MEM_result[0]) ||
                       (MEM_sizecontrol[1] && MEM_result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign start   = mem_op & ~misaligned;
  assign timeout = (state == ST_ACCESS) && !i_dm_ack && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_ACCESS;
      ST_ACCESS: if (i_dm_ack || timeout) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Stall is masked by reset so the pipeline is released the instant reset asserts.
  always_comb begin
    o_dm_req = (state == ST_ACCESS);
    o_dm_we  = (state == ST_ACCESS) & we_p1;
    o_stall  = i_rst && (((state == ST_IDLE) && start) || ((state == ST_ACCESS) && !i_dm_ack));
  end

  assign o_dm_addr  = addr_p1;
  assign o_dm_wdata = wdata_p1;
  assign o_dm_be    = be_p1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cnt <= '0;
    else if ((state == ST_ACCESS) && (next_state == ST_ACCESS)) cnt <= cnt + 1'b1;
    else cnt <= '0;
  end

  // p1: request fields captured on IDLE->ACCESS and held for the whole access
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
      be_p1    <= '0;
      we_p1    <= 1'b0;
      lo_p1    <= '0;
      size_p1  <= '0;
    end else if ((state == ST_IDLE) && start) begin
      addr_p1  <= {MEM_result[NBITS-1:2], 2'b00};
      wdata_p1 <= lane_replicate(MEM_sizecontrol[1:0], MEM_Rt);
      be_p1    <= byte_enable(MEM_sizecontrol[1:0], MEM_result[1:0]);
      we_p1    <= MEM_memwrite;
      lo_p1    <= MEM_result[1:0];
      size_p1  <= MEM_sizecontrol[2:0];
    end
  end

  load_aligner u_load_aligner (
    .rdata (i_dm_rdata),
    .lo    (lo_p1),
    .size  (size_p1),
    .data  (aligned)
  );

  // MEM/WB boundary: load on pass-through or ack, otherwise emit a bubble
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      WB_readdata <= '0;
      WB_result   <= '0;
      WB_rd       <= '0;
      WB_memtoreg <= 1'b0;
      WB_regwrite <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_bus_err <= timeout;
      if ((state == ST_IDLE) && !start) begin
        WB_result   <= MEM_result;
        WB_rd       <= MEM_rd;
        WB_memtoreg <= MEM_memtoreg & ~misaligned;
        WB_regwrite <= MEM_regwrite & ~misaligned;
      end else if ((state == ST_ACCESS) && i_dm_ack) begin
        WB_readdata <= aligned;
        WB_result   <= MEM_result;
        WB_rd       <= MEM_rd;
        WB_memtoreg <= MEM_memtoreg;
        WB_regwrite <= MEM_regwrite;
      end else begin
        WB_memtoreg <= 1'b0;
        WB_regwrite <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_misalign <= 1'b0;
    else        o_misalign <= (state == ST_IDLE) && misaligned;
  end
`endif

endmodule
